pulse_sched_seq: RTL and testbench

Parametrised timed pulse sequencer that succeeds the single-shot start controller. It keeps the free-running system time with second-mark resync, buffers up to DEPTH timed commands, and executes each as N repeated blank1/emit/blank2/receive periods. It drives the DDS parameter/start and the En_Iz/En_Pr gates.

---
 rtl/pulse_sched_seq.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_pulse_sched_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sched_seq.sv
// -----------------------------------------------------------------------------
// pulse_sched_seq
// Timed pulse sequencer. Keeps the free-running system time (resynchronised on
// the T1hz second mark), buffers up to DEPTH timed commands and runs each one
// as max(N,1) periods of BLANK1 / TIZL (En_Iz) / BLANK2 / TPR (En_Pr).
//
// Optional feature macro: PULSE_SCHED_LATE_START_EN
//   defined     : a late head is popped and started immediately (CMD_LATE pulses)
//   not defined : a late head is popped and discarded (CMD_LATE pulses)
//
// Ports
//   CLK, RESET_N                 clock, async active-low reset
//   SYS_TIME, SYS_TIME_UPDATE    time value / arm load on next T1hz rise
//   T1hz                         asynchronous second mark
//   SYS_TIME_UPDATE_OK           1-cycle pulse on time load
//   TIME_NOW                     current system time
//   WR_DATA, MEM_*               command push and fields
//   ABORT                        stop current command, flush queue
//   CMD_READY / CMD_OVF / CMD_LATE   queue not full / push rejected / late head
//   DDS_freq, DDS_delta_freq, DDS_delta_rate, DDS_start   DDS controls
//   En_Iz, En_Pr                 emit / receive gates
//   BUSY, PULSE_IDX              sequencer active, current impulse index
// -----------------------------------------------------------------------------
module pulse_sched_seq #(
   parameter int TIME_W = 64,
   parameter int CNT_W  = 32,
   parameter int NP_W   = 16,
   parameter int FREQ_W = 48,
   parameter int RATE_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic [TIME_W-1:0] SYS_TIME,
   input  logic              SYS_TIME_UPDATE,
   input  logic              T1hz,
   output logic              SYS_TIME_UPDATE_OK,
   output logic [TIME_W-1:0] TIME_NOW,
   input  logic              WR_DATA,
   input  logic [FREQ_W-1:0] MEM_DDS_freq,
   input  logic [FREQ_W-1:0] MEM_DDS_delta_freq,
   input  logic [RATE_W-1:0] MEM_DDS_delta_rate,
   input  logic [TIME_W-1:0] MEM_TIME_START,
   input  logic [NP_W-1:0]   MEM_N_impuls,
   input  logic [CNT_W-1:0]  MEM_Tblank1,
   input  logic [CNT_W-1:0]  MEM_Interval_Ti,
   input  logic [CNT_W-1:0]  MEM_Tblank2,
   input  logic [CNT_W-1:0]  MEM_Interval_Tp,
   input  logic              ABORT,
   output logic              CMD_READY,
   output logic              CMD_OVF,
   output logic              CMD_LATE,
   output logic [FREQ_W-1:0] DDS_freq,
   output logic [FREQ_W-1:0] DDS_delta_freq,
   output logic [RATE_W-1:0] DDS_delta_rate,
   output logic              DDS_start,
   output logic              En_Iz,
   output logic              En_Pr,
   output logic              BUSY,
   output logic [NP_W-1:0]   PULSE_IDX
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] QD = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_BLANK1, S_TIZL, S_BLANK2, S_TPR} state_t;

   // zero-length phases still take one cycle
   function automatic logic [CNT_W-1:0] atl1(input logic [CNT_W-1:0] k);
      return (k == '0) ? CNT_W'(1) : k;
   endfunction

   // ---------------- system time ----------------
   logic              r_t1_s1, r_t1_s2, r_t1_d;
   logic [TIME_W-1:0] r_time;
   logic              r_upd_ok;
   logic              w_t1_rise;

   assign w_t1_rise = r_t1_s2 & ~r_t1_d;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_t1_s1  <= 1'b0;
         r_t1_s2  <= 1'b0;
         r_t1_d   <= 1'b0;
         r_time   <= '0;
         r_upd_ok <= 1'b0;
      end else begin
         r_t1_s1  <= T1hz;
         r_t1_s2  <= r_t1_s1;
         r_t1_d   <= r_t1_s2;
         r_upd_ok <= w_t1_rise & SYS_TIME_UPDATE;
         if (w_t1_rise && SYS_TIME_UPDATE) r_time <= SYS_TIME;
         else                              r_time <= r_time + TIME_W'(1);
      end
   end

   // ---------------- command queue ----------------
   logic [FREQ_W-1:0] r_q_freq  [DEPTH];
   logic [FREQ_W-1:0] r_q_dfreq [DEPTH];
   logic [RATE_W-1:0] r_q_rate  [DEPTH];
   logic [TIME_W-1:0] r_q_start [DEPTH];
   logic [NP_W-1:0]   r_q_n     [DEPTH];
   logic [CNT_W-1:0]  r_q_tb1   [DEPTH];
   logic [CNT_W-1:0]  r_q_ti    [DEPTH];
   logic [CNT_W-1:0]  r_q_tb2   [DEPTH];
   logic [CNT_W-1:0]  r_q_tp    [DEPTH];
   logic [AW-1:0]     r_wp, r_rp;
   logic [AW:0]       r_qcnt;
   logic              r_ready;

   logic              w_full, w_empty, w_push, w_ovf, w_pop;
   logic [AW:0]       w_qcnt_nxt;
   logic [TIME_W-1:0] w_diff;
   logic              w_match, w_late;

   assign w_full  = (r_qcnt == QD);
   assign w_empty = (r_qcnt == '0);
   // readiness is judged on the pre-pop fill level
   assign w_push  = WR_DATA & ~w_full & ~ABORT;
   assign w_ovf   = WR_DATA & w_full;

   // modular distance to the head start time; MSB set means already passed
   assign w_diff  = r_q_start[r_rp] - r_time;
   assign w_match = (w_diff == '0);
   assign w_late  = w_diff[TIME_W-1];

   always_comb begin
      w_qcnt_nxt = r_qcnt;
      if (ABORT)                  w_qcnt_nxt = '0;
      else if (w_push && !w_pop)  w_qcnt_nxt = r_qcnt + (AW+1)'(1);
      else if (!w_push && w_pop)  w_qcnt_nxt = r_qcnt - (AW+1)'(1);
   end

   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_q_freq[r_wp]  <= MEM_DDS_freq;
         r_q_dfreq[r_wp] <= MEM_DDS_delta_freq;
         r_q_rate[r_wp]  <= MEM_DDS_delta_rate;
         r_q_start[r_wp] <= MEM_TIME_START;
         r_q_n[r_wp]     <= MEM_N_impuls;
         r_q_tb1[r_wp]   <= MEM_Tblank1;
         r_q_ti[r_wp]    <= MEM_Interval_Ti;
         r_q_tb2[r_wp]   <= MEM_Tblank2;
         r_q_tp[r_wp]    <= MEM_Interval_Tp;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_qcnt  <= '0;
         r_ready <= 1'b1;
      end else begin
         r_qcnt  <= w_qcnt_nxt;
         r_ready <= (w_qcnt_nxt != QD);
         if (ABORT) begin
            r_wp <= '0;
            r_rp <= '0;
         end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
         end
      end
   end

   // ---------------- sequencer FSM ----------------
   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_ph;
   logic [CNT_W-1:0] r_tb1, r_ti, r_tb2, r_tp;
   logic [NP_W-1:0]  r_n, r_idx;
   logic             w_start, w_late_evt, w_ph_load, w_idx_inc, w_last;
   logic [CNT_W-1:0] w_ph_val;
   logic [NP_W-1:0]  w_nmax;

   assign w_nmax = (r_n == '0) ? NP_W'(1) : r_n;
   assign w_last = !(({1'b0, r_idx} + (NP_W+1)'(1)) < {1'b0, w_nmax});

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_start     = 1'b0;
      w_late_evt  = 1'b0;
      w_ph_load   = 1'b0;
      w_ph_val    = '0;
      w_idx_inc   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               if (w_match) begin
                  w_pop       = 1'b1;
                  w_start     = 1'b1;
                  w_state_nxt = S_BLANK1;
                  w_ph_load   = 1'b1;
                  w_ph_val    = atl1(r_q_tb1[r_rp]);
               end else if (w_late) begin
                  w_pop      = 1'b1;
                  w_late_evt = 1'b1;
`ifdef PULSE_SCHED_LATE_START_EN
                  w_start     = 1'b1;
                  w_state_nxt = S_BLANK1;
                  w_ph_load   = 1'b1;
                  w_ph_val    = atl1(r_q_tb1[r_rp]);
`else
                  w_state_nxt = S_IDLE;
`endif
               end
            end
         end
         S_BLANK1: if (r_ph == CNT_W'(1)) begin
            w_state_nxt = S_TIZL;
            w_ph_load   = 1'b1;
            w_ph_val    = atl1(r_ti);
         end
         S_TIZL: if (r_ph == CNT_W'(1)) begin
            w_state_nxt = S_BLANK2;
            w_ph_load   = 1'b1;
            w_ph_val    = atl1(r_tb2);
         end
         S_BLANK2: if (r_ph == CNT_W'(1)) begin
            w_state_nxt = S_TPR;
            w_ph_load   = 1'b1;
            w_ph_val    = atl1(r_tp);
         end
         S_TPR: if (r_ph == CNT_W'(1)) begin
            if (w_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_idx_inc   = 1'b1;
               w_state_nxt = S_BLANK1;
               w_ph_load   = 1'b1;
               w_ph_val    = atl1(r_tb1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // abort overrides everything, including a pending pop/start
      if (ABORT) begin
         w_state_nxt = S_IDLE;
         w_pop       = 1'b0;
         w_start     = 1'b0;
         w_late_evt  = 1'b0;
         w_ph_load   = 1'b0;
         w_idx_inc   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state        <= S_IDLE;
         r_ph           <= '0;
         r_tb1          <= '0;
         r_ti           <= '0;
         r_tb2          <= '0;
         r_tp           <= '0;
         r_n            <= '0;
         r_idx          <= '0;
         DDS_freq       <= '0;
         DDS_delta_freq <= '0;
         DDS_delta_rate <= '0;
         DDS_start      <= 1'b0;
         En_Iz          <= 1'b0;
         En_Pr          <= 1'b0;
         BUSY           <= 1'b0;
         CMD_OVF        <= 1'b0;
         CMD_LATE       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ph_load)                                  r_ph <= w_ph_val;
         else if (r_state != S_IDLE && r_ph != CNT_W'(1)) r_ph <= r_ph - CNT_W'(1);
         if (w_start) begin
            r_tb1          <= r_q_tb1[r_rp];
            r_ti           <= r_q_ti[r_rp];
            r_tb2          <= r_q_tb2[r_rp];
            r_tp           <= r_q_tp[r_rp];
            r_n            <= r_q_n[r_rp];
            r_idx          <= '0;
            DDS_freq       <= r_q_freq[r_rp];
            DDS_delta_freq <= r_q_dfreq[r_rp];
            DDS_delta_rate <= r_q_rate[r_rp];
         end else if (w_idx_inc) begin
            r_idx <= r_idx + NP_W'(1);
         end
         // gates follow the next state so they switch exactly on entry/exit
         DDS_start <= w_start;
         En_Iz     <= (w_state_nxt == S_TIZL);
         En_Pr     <= (w_state_nxt == S_TPR);
         BUSY      <= (w_state_nxt != S_IDLE);
         CMD_OVF   <= w_ovf;
         CMD_LATE  <= w_late_evt;
      end
   end

   assign TIME_NOW           = r_time;
   assign SYS_TIME_UPDATE_OK = r_upd_ok;
   assign CMD_READY          = r_ready;
   assign PULSE_IDX          = r_idx;

endmodule

// File: tb/tb_pulse_sched_seq.sv
// -----------------------------------------------------------------------------
// tb_pulse_sched_seq
// Directed self-checking bench for pulse_sched_seq (default parameters).
// Inputs change and outputs are sampled 1 ns after each rising CLK edge.
// The bench keeps its own model of TIME_NOW (base value + cycles elapsed).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pulse_sched_seq;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [63:0] SYS_TIME = '0;
   logic        SYS_TIME_UPDATE = 1'b0;
   logic        T1hz = 1'b0;
   logic        SYS_TIME_UPDATE_OK;
   logic [63:0] TIME_NOW;
   logic        WR_DATA = 1'b0;
   logic [47:0] MEM_DDS_freq = '0, MEM_DDS_delta_freq = '0;
   logic [31:0] MEM_DDS_delta_rate = '0;
   logic [63:0] MEM_TIME_START = '0;
   logic [15:0] MEM_N_impuls = '0;
   logic [31:0] MEM_Tblank1 = '0, MEM_Interval_Ti = '0, MEM_Tblank2 = '0, MEM_Interval_Tp = '0;
   logic        ABORT = 1'b0;
   logic        CMD_READY, CMD_OVF, CMD_LATE;
   logic [47:0] DDS_freq, DDS_delta_freq;
   logic [31:0] DDS_delta_rate;
   logic        DDS_start, En_Iz, En_Pr, BUSY;
   logic [15:0] PULSE_IDX;

   pulse_sched_seq dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .SYS_TIME(SYS_TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .T1hz(T1hz),
      .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .TIME_NOW(TIME_NOW),
      .WR_DATA(WR_DATA),
      .MEM_DDS_freq(MEM_DDS_freq), .MEM_DDS_delta_freq(MEM_DDS_delta_freq),
      .MEM_DDS_delta_rate(MEM_DDS_delta_rate), .MEM_TIME_START(MEM_TIME_START),
      .MEM_N_impuls(MEM_N_impuls), .MEM_Tblank1(MEM_Tblank1),
      .MEM_Interval_Ti(MEM_Interval_Ti), .MEM_Tblank2(MEM_Tblank2),
      .MEM_Interval_Tp(MEM_Interval_Tp),
      .ABORT(ABORT), .CMD_READY(CMD_READY), .CMD_OVF(CMD_OVF), .CMD_LATE(CMD_LATE),
      .DDS_freq(DDS_freq), .DDS_delta_freq(DDS_delta_freq), .DDS_delta_rate(DDS_delta_rate),
      .DDS_start(DDS_start), .En_Iz(En_Iz), .En_Pr(En_Pr), .BUSY(BUSY), .PULSE_IDX(PULSE_IDX)
   );

   always #5 CLK = ~CLK;

   int          total = 0;
   int          bad = 0;
   longint      cyc = 0, c_base = 0;
   logic [63:0] t_base = '0;

   // activity observed since the last clr()
   int          n_start, n_iz, n_iz_rise, n_pr, n_pr_rise, n_busy, n_late, n_ovf, n_ok;
   logic [63:0] t_iz_rise, t_pr_rise, t_late;
   logic [63:0] st_t [8];
   logic [47:0] st_f [8];
   logic [15:0] idx_max;
   logic        p_iz, p_pr;

   function automatic logic [63:0] tnow();
      return t_base + 64'(cyc - c_base);
   endfunction

   task automatic clr();
      n_start = 0; n_iz = 0; n_iz_rise = 0; n_pr = 0; n_pr_rise = 0;
      n_busy = 0; n_late = 0; n_ovf = 0; n_ok = 0; idx_max = '0;
      t_iz_rise = '0; t_pr_rise = '0; t_late = '0;
      p_iz = En_Iz; p_pr = En_Pr;
   endtask

   task automatic step();
      @(posedge CLK); #1;
      cyc++;
      if (DDS_start) begin
         if (n_start < 8) begin st_t[n_start] = tnow(); st_f[n_start] = DDS_freq; end
         n_start++;
      end
      if (En_Iz) n_iz++;
      if (En_Iz && !p_iz) begin n_iz_rise++; t_iz_rise = tnow(); end
      if (En_Pr) n_pr++;
      if (En_Pr && !p_pr) begin n_pr_rise++; t_pr_rise = tnow(); end
      p_iz = En_Iz; p_pr = En_Pr;
      if (BUSY) n_busy++;
      if (CMD_LATE) begin n_late++; t_late = tnow(); end
      if (CMD_OVF) n_ovf++;
      if (SYS_TIME_UPDATE_OK) n_ok++;
      if (PULSE_IDX > idx_max) idx_max = PULSE_IDX;
   endtask

   task automatic push_cmd(input logic [63:0] st, input logic [47:0] f, input logic [15:0] n,
                           input logic [31:0] tb1, input logic [31:0] ti,
                           input logic [31:0] tb2, input logic [31:0] tp);
      MEM_TIME_START = st; MEM_DDS_freq = f; MEM_DDS_delta_freq = f + 48'd1;
      MEM_DDS_delta_rate = 32'h55; MEM_N_impuls = n;
      MEM_Tblank1 = tb1; MEM_Interval_Ti = ti; MEM_Tblank2 = tb2; MEM_Interval_Tp = tp;
      WR_DATA = 1'b1;
      step();
      WR_DATA = 1'b0;
   endtask

   task automatic run_until(input logic [63:0] t);
      while (tnow() != t) step();
   endtask

   task automatic test_reset();
      repeat (3) step();
      total++; if (TIME_NOW !== 64'd0) begin bad++; $display("FAIL reset_time got=%0d exp=0", TIME_NOW); end
      total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
      total++; if ({BUSY, DDS_start, En_Iz, En_Pr, CMD_OVF, CMD_LATE, SYS_TIME_UPDATE_OK} !== 7'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0", {BUSY, DDS_start, En_Iz, En_Pr, CMD_OVF, CMD_LATE, SYS_TIME_UPDATE_OK}); end
      total++; if ({DDS_freq, PULSE_IDX} !== 64'd0) begin bad++; $display("FAIL reset_dds got=%h exp=0", {DDS_freq, PULSE_IDX}); end
      RESET_N = 1'b1;
      c_base = cyc; t_base = '0;
      clr();
      step();
      total++; if (TIME_NOW !== 64'd1) begin bad++; $display("FAIL first_tick got=%0d exp=1", TIME_NOW); end
      repeat (10) step();
      total++; if (TIME_NOW !== tnow()) begin bad++; $display("FAIL free_run got=%0d exp=%0d", TIME_NOW, tnow()); end
   endtask

   task automatic test_time_load();
      clr();
      SYS_TIME = 64'd1000; SYS_TIME_UPDATE = 1'b1; T1hz = 1'b1;
      step(); step();
      T1hz = 1'b0;
      step();
      // third edge after the mark loads the time
      total++; if (TIME_NOW !== 64'd1000) begin bad++; $display("FAIL load_value got=%0d exp=1000", TIME_NOW); end
      total++; if (SYS_TIME_UPDATE_OK !== 1'b1) begin bad++; $display("FAIL load_ok got=%b exp=1", SYS_TIME_UPDATE_OK); end
      t_base = 64'd1000; c_base = cyc;
      SYS_TIME_UPDATE = 1'b0;
      repeat (5) step();
      total++; if (n_ok != 1) begin bad++; $display("FAIL load_ok_once got=%0d exp=1", n_ok); end
      total++; if (TIME_NOW !== 64'd1005) begin bad++; $display("FAIL load_count got=%0d exp=1005", TIME_NOW); end
      // mark without the update flag must not load
      clr();
      SYS_TIME = 64'd5000; T1hz = 1'b1;
      step(); step();
      T1hz = 1'b0;
      repeat (6) step();
      total++; if (n_ok != 0) begin bad++; $display("FAIL noload_ok got=%0d exp=0", n_ok); end
      total++; if (TIME_NOW !== tnow()) begin bad++; $display("FAIL noload_time got=%0d exp=%0d", TIME_NOW, tnow()); end
   endtask

   task automatic test_basic();
      logic [63:0] s;
      clr();
      s = tnow() + 64'd20;
      push_cmd(s, 48'h1234_5678_9ABC, 16'd1, 32'd3, 32'd5, 32'd2, 32'd7);
      run_until(s + 64'd25);
      total++; if (n_start != 1 || st_t[0] !== s + 64'd1) begin bad++; $display("FAIL basic_start n=%0d at=%0d exp_at=%0d", n_start, st_t[0], s + 64'd1); end
      total++; if (t_iz_rise !== s + 64'd4) begin bad++; $display("FAIL basic_iz_rise got=%0d exp=%0d", t_iz_rise, s + 64'd4); end
      total++; if (n_iz != 5) begin bad++; $display("FAIL basic_iz_len got=%0d exp=5", n_iz); end
      total++; if (t_pr_rise !== s + 64'd11) begin bad++; $display("FAIL basic_pr_rise got=%0d exp=%0d", t_pr_rise, s + 64'd11); end
      total++; if (n_pr != 7) begin bad++; $display("FAIL basic_pr_len got=%0d exp=7", n_pr); end
      total++; if (n_busy != 17 || BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy got=%0d/%b exp=17/0", n_busy, BUSY); end
      total++; if (DDS_freq !== 48'h1234_5678_9ABC || DDS_delta_freq !== 48'h1234_5678_9ABD || DDS_delta_rate !== 32'h55) begin
         bad++; $display("FAIL basic_dds_hold got=%h/%h/%h", DDS_freq, DDS_delta_freq, DDS_delta_rate); end
   endtask

   task automatic test_repeats();
      logic [63:0] s;
      clr();
      s = tnow() + 64'd10;
      push_cmd(s, 48'd77, 16'd3, 32'd2, 32'd4, 32'd1, 32'd3);
      run_until(s + 64'd40);
      total++; if (n_start != 1) begin bad++; $display("FAIL rep_start got=%0d exp=1", n_start); end
      total++; if (n_iz_rise != 3 || n_iz != 12) begin bad++; $display("FAIL rep_iz got=%0d/%0d exp=3/12", n_iz_rise, n_iz); end
      total++; if (n_pr_rise != 3 || n_pr != 9) begin bad++; $display("FAIL rep_pr got=%0d/%0d exp=3/9", n_pr_rise, n_pr); end
      total++; if (idx_max !== 16'd2 || n_busy != 30) begin bad++; $display("FAIL rep_idx got=%0d busy=%0d exp=2/30", idx_max, n_busy); end
   endtask

   task automatic test_zero_len();
      logic [63:0] s;
      clr();
      s = tnow() + 64'd8;
      push_cmd(s, 48'd5, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      run_until(s + 64'd12);
      total++; if (n_iz != 1 || t_iz_rise !== s + 64'd2) begin bad++; $display("FAIL zero_iz got=%0d at=%0d exp=1 at %0d", n_iz, t_iz_rise, s + 64'd2); end
      total++; if (n_pr != 1 || n_busy != 4 || PULSE_IDX !== 16'd0) begin bad++; $display("FAIL zero_pr got=%0d busy=%0d idx=%0d exp=1/4/0", n_pr, n_busy, PULSE_IDX); end
   endtask

   task automatic test_queue_full();
      logic [63:0] s;
      clr();
      s = tnow() + 64'd30;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL q_ready_%0d got=%b exp=1", i, CMD_READY); end
         end
         push_cmd(s + 64'(20 * i), 48'(100 + i), 16'd1, 32'd1, 32'd2, 32'd1, 32'd2);
         if (i == 3) begin
            total++; if (CMD_READY !== 1'b0) begin bad++; $display("FAIL q_full got=%b exp=0", CMD_READY); end
         end
      end
      total++; if (CMD_OVF !== 1'b1) begin bad++; $display("FAIL q_ovf got=%b exp=1", CMD_OVF); end
      step();
      total++; if (CMD_OVF !== 1'b0) begin bad++; $display("FAIL q_ovf_pulse got=%b exp=0", CMD_OVF); end
      run_until(s + 64'd100);
      total++; if (n_start != 4 || n_ovf != 1) begin bad++; $display("FAIL q_count starts=%0d ovf=%0d exp=4/1", n_start, n_ovf); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (st_t[i] !== s + 64'(20 * i + 1) || st_f[i] !== 48'(100 + i)) begin
            bad++; $display("FAIL q_order_%0d at=%0d f=%0d exp at=%0d f=%0d", i, st_t[i], st_f[i], s + 64'(20 * i + 1), 100 + i);
         end
      end
      total++; if (n_iz != 8 || CMD_READY !== 1'b1) begin bad++; $display("FAIL q_drain iz=%0d ready=%b exp=8/1", n_iz, CMD_READY); end
   endtask

   task automatic test_abort();
      logic [63:0] s;
      clr();
      s = tnow() + 64'd10;
      push_cmd(s, 48'd1, 16'd1, 32'd2, 32'd10, 32'd1, 32'd1);
      push_cmd(s + 64'd100, 48'd2, 16'd1, 32'd1, 32'd1, 32'd1, 32'd1);
      push_cmd(s + 64'd200, 48'd3, 16'd1, 32'd1, 32'd1, 32'd1, 32'd1);
      run_until(s + 64'd6);
      total++; if (En_Iz !== 1'b1) begin bad++; $display("FAIL abort_pre_iz got=%b exp=1", En_Iz); end
      // abort together with a push: the push must be discarded too
      ABORT = 1'b1;
      MEM_TIME_START = s + 64'd50; WR_DATA = 1'b1;
      step();
      ABORT = 1'b0; WR_DATA = 1'b0;
      total++; if (En_Iz !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL abort_stop iz=%b busy=%b exp=0/0", En_Iz, BUSY); end
      total++; if (CMD_READY !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b exp=1", CMD_READY); end
      clr();
      run_until(s + 64'd220);
      total++; if (n_start != 0 || n_busy != 0) begin bad++; $display("FAIL abort_flush starts=%0d busy=%0d exp=0/0", n_start, n_busy); end
   endtask

   task automatic test_late();
      logic [63:0] t0;
      clr();
      t0 = tnow();
      push_cmd(t0 - 64'd5, 48'd9, 16'd1, 32'd1, 32'd1, 32'd1, 32'd1);
      run_until(t0 + 64'd15);
      total++; if (n_late != 1 || t_late !== t0 + 64'd2) begin bad++; $display("FAIL late_pulse n=%0d at=%0d exp=1 at %0d", n_late, t_late, t0 + 64'd2); end
`ifdef PULSE_SCHED_LATE_START_EN
      total++; if (n_start != 1 || st_t[0] !== t0 + 64'd2 || n_busy != 4) begin
         bad++; $display("FAIL late_exec starts=%0d at=%0d busy=%0d exp=1 at %0d busy 4", n_start, st_t[0], n_busy, t0 + 64'd2); end
`else
      total++; if (n_start != 0 || n_busy != 0) begin bad++; $display("FAIL late_drop starts=%0d busy=%0d exp=0/0", n_start, n_busy); end
`endif
      total++; if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL late_idle ready=%b busy=%b exp=1/0", CMD_READY, BUSY); end
   endtask

   initial begin
      clr();
      test_reset();
      test_time_load();
      test_basic();
      test_repeats();
      test_zero_len();
      test_queue_full();
      test_abort();
      test_late();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
